// File: rtl/marin_pkg.sv
// Shared Marin SoC definitions for the Wishbone UART transmitter:
// register offsets, STATUS bit positions and the TX state encoding.
package marin_pkg;

   localparam logic [1:0] UART_REG_TXDATA = 2'd0;
   localparam logic [1:0] UART_REG_STATUS = 2'd1;
   localparam logic [1:0] UART_REG_DIV    = 2'd2;
   localparam logic [1:0] UART_REG_RSVD   = 2'd3;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_IRQ_EN  = 4;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Divisors below 2 would make a state shorter than the handshake can follow.
   function automatic logic [15:0] bit_period(input logic [15:0] div);
      bit_period = (div < 16'd2) ? 16'd2 : div;
   endfunction

endpackage

// File: rtl/wb_uart_tx16_sync_fifo8.sv
// Byte-wide synchronous circular FIFO with wrap-bit pointers.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo8
   import marin_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [7:0]    din_i,
   output logic [7:0]    dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

   logic [7:0]  mem_q [0:(1<<AW)-1];
   logic [AW:0] wr_q;
   logic [AW:0] wr_d;
   logic [AW:0] rd_q;
   logic [AW:0] rd_d;
   logic        do_push_s;
   logic        do_pop_s;

   assign count_o = wr_q - rd_q;
   assign full_o  = (count_o == CNT_FULL);
   assign empty_o = (wr_q == rd_q);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   // Pointer advance; the pop decision uses the state before this edge's push.
   always_comb begin
      do_push_s = push_i && !full_o;
      do_pop_s  = pop_i && !empty_o;
      if (do_push_s) begin
         wr_d = wr_q + PTR_ONE;
      end else begin
         wr_d = wr_q;
      end
      if (do_pop_s) begin
         rd_d = rd_q + PTR_ONE;
      end else begin
         rd_d = rd_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_q[AW-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/wb_uart_tx16.sv
// 16-bit Wishbone classic slave UART transmitter (8N1, LSB first) with a byte FIFO.
// Optional WB_UART_TX_IRQ_EN adds irq_o and the STATUS[4] interrupt enable.
module wb_uart_tx16
   import marin_pkg::*;
#(
   parameter int          FIFO_AW     = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [15:0]   wb_dat_i,
   output logic [15:0]   wb_dat_o,
   input  logic [31:0]   wb_adr_i,
   input  logic [1:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   output logic          wb_ack_o,
   output logic          tx_o
`ifdef WB_UART_TX_IRQ_EN
   ,
   output logic          irq_o
`endif
);

   logic              ack_q;
   logic              ack_d;
   logic [15:0]       dat_q;
   logic [15:0]       dat_d;
   logic [15:0]       div_q;
   logic [15:0]       div_d;
   logic              ovf_q;
   logic              ovf_d;
   logic [1:0]        reg_s;
   logic              access_s;
   logic              push_req_s;
   logic              pop_s;
   logic [15:0]       status_s;
   logic [15:0]       per_new_s;
   logic [7:0]        fifo_dout_s;
   logic              full_s;
   logic              empty_s;
   logic [FIFO_AW:0]  count_s;
   logic              unused_adr_s;

   tx_state_e         state_q;
   logic [15:0]       cnt_q;
   logic [15:0]       per_q;
   logic [7:0]        sh_q;
   logic [2:0]        bit_q;
   logic              tx_q;

`ifdef WB_UART_TX_IRQ_EN
   logic              irq_en_q;
   logic              irq_en_d;
   logic              irq_q;
   logic              irq_d;
   assign irq_o = irq_q;
`endif

   assign reg_s        = wb_adr_i[2:1];
   assign unused_adr_s = ^{wb_adr_i[31:3], wb_adr_i[0]};
   assign wb_ack_o     = ack_q;
   assign wb_dat_o     = dat_q;
   assign tx_o         = tx_q;

   sync_fifo8 #(
      .AW      (FIFO_AW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .push_i  (push_req_s),
      .pop_i   (pop_s),
      .din_i   (wb_dat_i[7:0]),
      .dout_o  (fifo_dout_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count_s)
   );

   // STATUS word assembly.
   always_comb begin
      status_s                          = 16'd0;
      status_s[ST_FULL]                 = full_s;
      status_s[ST_EMPTY]                = empty_s;
      status_s[ST_BUSY]                 = (state_q != TX_IDLE);
      status_s[ST_OVF]                  = ovf_q;
      status_s[ST_CNT_LSB +: FIFO_AW+1] = count_s;
`ifdef WB_UART_TX_IRQ_EN
      status_s[ST_IRQ_EN]               = irq_en_q;
`endif
   end

   // Bus decode: every side effect is tied to the single cycle that raises ack.
   always_comb begin
      access_s   = wb_cyc_i && wb_stb_i && !ack_q;
      ack_d      = access_s;
      push_req_s = access_s && wb_we_i && (reg_s == UART_REG_TXDATA) && wb_sel_i[0];
      div_d      = div_q;
      ovf_d      = ovf_q;
      dat_d      = 16'd0;
      if (access_s && !wb_we_i) begin
         case (reg_s)
            UART_REG_STATUS: dat_d = status_s;
            UART_REG_DIV:    dat_d = div_q;
            default:         dat_d = 16'd0;
         endcase
      end else begin
         dat_d = 16'd0;
      end
      if (access_s && wb_we_i && (reg_s == UART_REG_DIV)) begin
         if (wb_sel_i[0]) begin
            div_d[7:0] = wb_dat_i[7:0];
         end else begin
            div_d[7:0] = div_q[7:0];
         end
         if (wb_sel_i[1]) begin
            div_d[15:8] = wb_dat_i[15:8];
         end else begin
            div_d[15:8] = div_q[15:8];
         end
      end else begin
         div_d = div_q;
      end
      if (push_req_s && full_s) begin
         ovf_d = 1'b1;
      end else if (access_s && wb_we_i && (reg_s == UART_REG_STATUS) &&
                   wb_sel_i[0] && wb_dat_i[ST_OVF]) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

`ifdef WB_UART_TX_IRQ_EN
   // Interrupt enable and level; a fresh push drops the request at once.
   always_comb begin
      irq_en_d = irq_en_q;
      if (access_s && wb_we_i && (reg_s == UART_REG_STATUS) && wb_sel_i[0]) begin
         irq_en_d = wb_dat_i[ST_IRQ_EN];
      end else begin
         irq_en_d = irq_en_q;
      end
      irq_d = irq_en_q && empty_s && (state_q == TX_IDLE) && !push_req_s;
   end

   // Interrupt registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end
`endif

   // Bus-side registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_q <= 1'b0;
         dat_q <= 16'd0;
         div_q <= DEFAULT_DIV;
         ovf_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         div_q <= div_d;
         ovf_q <= ovf_d;
      end
   end

   // A new frame starts from IDLE or straight out of an expiring stop bit.
   always_comb begin
      per_new_s = bit_period(div_q);
      if (!empty_s && ((state_q == TX_IDLE) ||
                       ((state_q == TX_STOP) && (cnt_q == 16'd0)))) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Transmit FSM; cnt_q counts down the remaining cycles of the current bit.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= TX_IDLE;
         cnt_q   <= 16'd0;
         per_q   <= 16'd2;
         sh_q    <= 8'd0;
         bit_q   <= 3'd0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (pop_s) begin
                  state_q <= TX_START;
                  per_q   <= per_new_s;
                  cnt_q   <= per_new_s - 16'd1;
                  sh_q    <= fifo_dout_s;
                  tx_q    <= 1'b0;
               end
            end
            TX_START: begin
               if (cnt_q == 16'd0) begin
                  state_q <= TX_DATA;
                  cnt_q   <= per_q - 16'd1;
                  bit_q   <= 3'd0;
                  tx_q    <= sh_q[0];
               end else begin
                  cnt_q   <= cnt_q - 16'd1;
               end
            end
            TX_DATA: begin
               if (cnt_q == 16'd0) begin
                  cnt_q <= per_q - 16'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= TX_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     sh_q  <= {1'b0, sh_q[7:1]};
                     tx_q  <= sh_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            TX_STOP: begin
               if (cnt_q == 16'd0) begin
                  if (pop_s) begin
                     state_q <= TX_START;
                     per_q   <= per_new_s;
                     cnt_q   <= per_new_s - 16'd1;
                     sh_q    <= fifo_dout_s;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            default: begin
               state_q <= TX_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_uart_tx16.sv
// Directed/randomised bench for wb_uart_tx16: bus accesses are checked inline,
// the serial line is logged every cycle and compared with frames built from the bytes sent.
module tb_wb_uart_tx16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic [31:0] wb_adr_i;
   logic [1:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic        tx_o;
`ifdef WB_UART_TX_IRQ_EN
   logic        irq_o;
   bit          m_irq_en = 1'b0;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   bit          hist [0:32767];
   int          cyc_cnt = 0;

   logic [15:0] m_div;
   bit          m_ovf;
   int          m_lvl;
   bit          m_shift;
   logic [7:0]  q[$];

   wb_uart_tx16 dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_adr_i (wb_adr_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_ack_o (wb_ack_o),
      .tx_o     (tx_o)
`ifdef WB_UART_TX_IRQ_EN
      ,
      .irq_o    (irq_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (cyc_cnt < 32768) hist[cyc_cnt] <= tx_o;
      cyc_cnt <= cyc_cnt + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One Wishbone classic access; ack must come exactly one cycle after stb and last one cycle.
   task automatic acc(input logic we, input logic [1:0] a, input logic [15:0] d,
                      input logic [1:0] sel, output logic [15:0] rd);
      wb_adr_i = {29'd0, a, 1'b0};
      wb_dat_i = d;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(posedge clk_i); #1;
      chk("ack_rise", wb_ack_o, 1);
      rd = wb_dat_o;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(posedge clk_i); #1;
      chk("ack_fall", wb_ack_o, 0);
      chk("dat_idle", wb_dat_o, 0);
   endtask

   function automatic logic [15:0] exp_status(input int lvl, input bit busy, input bit ovf);
      logic [15:0] w;
      w = 16'(lvl) << 8;
      if (lvl == 16) w = w | 16'h0001;
      if (lvl == 0)  w = w | 16'h0002;
      if (busy)      w = w | 16'h0004;
      if (ovf)       w = w | 16'h0008;
`ifdef WB_UART_TX_IRQ_EN
      if (m_irq_en)  w = w | 16'h0010;
`endif
      return w;
   endfunction

   task automatic check_status(input string tag, input int lvl, input bit busy, input bit ovf);
      logic [15:0] rd;
      acc(1'b0, 2'd1, 16'd0, 2'b11, rd);
      chk(tag, rd, exp_status(lvl, busy, ovf));
   endtask

   // Expected line: per byte a low start cell, 8 data cells LSB first, a high stop cell,
   // each 'per' cycles long, frames back to back, then idle high.
   task automatic check_stream(input int from, input int per, input string tag);
      int n;
      int s;
      int mism;
      logic e;
      n = q.size();
      s = -1;
      repeat (10 * per * n + per + 80) @(posedge clk_i);
      #1;
      for (int i = from; i < from + 60; i++) if (s < 0 && hist[i] == 1'b0) s = i;
      chk({tag, "_start_seen"}, (s >= 0) ? 1 : 0, 1);
      if (s < 0) s = from;
      for (int f = 0; f < n; f++) begin
         for (int b = 0; b < 10; b++) begin
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = q[f][b-1];
            mism = 0;
            for (int k = 0; k < per; k++)
               if (hist[s + (f * 10 + b) * per + k] !== e) mism++;
            chk($sformatf("%s_f%0d_cell%0d_badcycles", tag, f, b), mism, 0);
         end
      end
      mism = 0;
      for (int k = 0; k < per + 4; k++)
         if (hist[s + 10 * per * n + k] !== 1'b1) mism++;
      chk({tag, "_idle_after_badcycles"}, mism, 0);
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] d;
      logic [1:0]  sel;
      logic [7:0]  b;
      int          from;
      int          mism;

      rst_i = 1'b0;
      wb_dat_i = 16'd0; wb_adr_i = 32'd0; wb_sel_i = 2'b00;
      wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      m_div = 16'd868; m_ovf = 1'b0; m_lvl = 0; m_shift = 1'b0;
      repeat (3) @(posedge clk_i); #1;
      chk("rst_ack", wb_ack_o, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_tx", tx_o, 1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check_status("rst_status", 0, 0, 0);
      acc(1'b0, 2'd2, 16'd0, 2'b11, rd);
      chk("rst_div", rd, 16'd868);

      // Reset in the middle of a frame whose first data bit is low.
      acc(1'b1, 2'd2, 16'd40, 2'b11, rd);
      b = 8'($urandom) & 8'hFE;
      acc(1'b1, 2'd0, {8'd0, b}, 2'b01, rd);
      repeat (50) @(posedge clk_i); #3;
      chk("pre_rst_tx_low", tx_o, 0);
      rst_i = 1'b0;
      #1;
      chk("midframe_rst_tx_high", tx_o, 1);
      repeat (2) @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      m_div = 16'd868;
      check_status("post_rst_status", 0, 0, 0);
      acc(1'b0, 2'd2, 16'd0, 2'b11, rd);
      chk("post_rst_div", rd, m_div);
      from = cyc_cnt;
      repeat (100) @(posedge clk_i); #1;
      mism = 0;
      for (int i = from; i < from + 90; i++) if (hist[i] !== 1'b1) mism++;
      chk("post_rst_line_idle_badcycles", mism, 0);

      // Per-lane DIV writes with random data and byte enables.
      for (int i = 0; i < 6; i++) begin
         d = 16'($urandom);
         sel = 2'($urandom_range(0, 3));
         acc(1'b1, 2'd2, d, sel, rd);
         if (sel[0]) m_div[7:0] = d[7:0];
         if (sel[1]) m_div[15:8] = d[15:8];
         acc(1'b0, 2'd2, 16'd0, 2'b11, rd);
         chk($sformatf("div_lane_%0d", i), rd, m_div);
      end

      // DIV=4, 0xA5 frame.
      acc(1'b1, 2'd2, 16'd4, 2'b11, rd);
      m_div = 16'd4;
      q = {};
      q.push_back(8'hA5);
      from = cyc_cnt;
      acc(1'b1, 2'd0, 16'h00A5, 2'b01, rd);
      repeat (12) @(posedge clk_i); #1;
      check_status("a5_busy_status", 0, 1, 0);
      check_stream(from, 4, "a5");
      check_status("a5_done_status", 0, 0, 0);

      // Two bytes back to back: no idle gap between stop and next start.
      q = {};
      from = cyc_cnt;
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         acc(1'b1, 2'd0, {8'($urandom), b}, 2'b01, rd);
      end
      check_stream(from, 4, "b2b");
      check_status("b2b_done_status", 0, 0, 0);

      // Fill shifter plus FIFO, then overflow, clear, and confirm the dropped byte never appears.
      acc(1'b1, 2'd2, 16'd40, 2'b11, rd);
      m_div = 16'd40;
      q = {};
      m_lvl = 0; m_shift = 1'b0; m_ovf = 1'b0;
      from = cyc_cnt;
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom);
         acc(1'b1, 2'd0, {8'd0, b}, 2'b01, rd);
         q.push_back(b);
         if (!m_shift) m_shift = 1'b1;
         else if (m_lvl < 16) m_lvl++;
         else m_ovf = 1'b1;
      end
      check_status("fill_status", m_lvl, 1, m_ovf);
      b = 8'($urandom);
      acc(1'b1, 2'd0, {8'd0, b}, 2'b01, rd);
      if (m_lvl < 16) begin m_lvl++; q.push_back(b); end
      else m_ovf = 1'b1;
      check_status("ovf_status", m_lvl, 1, m_ovf);
      acc(1'b1, 2'd1, 16'h0008, 2'b01, rd);
      m_ovf = 1'b0;
      check_status("ovf_clear_status", m_lvl, 1, m_ovf);
      check_stream(from, 40, "ovf");
      check_status("ovf_done_status", 0, 0, 0);

      // DIV=1 and DIV=0 both give a 2-cycle bit.
      for (int v = 1; v >= 0; v--) begin
         acc(1'b1, 2'd2, 16'(v), 2'b11, rd);
         m_div = 16'(v);
         q = {};
         b = 8'($urandom);
         q.push_back(b);
         from = cyc_cnt;
         acc(1'b1, 2'd0, {8'd0, b}, 2'b01, rd);
         check_stream(from, 2, $sformatf("div%0d", v));
      end

      // Reserved and write-only reads.
      acc(1'b0, 2'd3, 16'd0, 2'b11, rd);
      chk("rsvd_read", rd, 0);
      acc(1'b1, 2'd3, 16'hFFFF, 2'b11, rd);
      acc(1'b0, 2'd2, 16'd0, 2'b11, rd);
      chk("rsvd_write_no_div_effect", rd, m_div);
      acc(1'b0, 2'd0, 16'd0, 2'b11, rd);
      chk("txdata_read", rd, 0);
      check_status("rsvd_write_no_status_effect", 0, 0, 0);

`ifdef WB_UART_TX_IRQ_EN
      acc(1'b1, 2'd2, 16'd4, 2'b11, rd);
      m_div = 16'd4;
      acc(1'b1, 2'd1, 16'h0010, 2'b01, rd);
      m_irq_en = 1'b1;
      check_status("irq_en_status", 0, 0, 0);
      chk("irq_idle_high", irq_o, 1);
      q = {};
      b = 8'($urandom);
      q.push_back(b);
      from = cyc_cnt;
      acc(1'b1, 2'd0, {8'd0, b}, 2'b01, rd);
      chk("irq_drop_on_write", irq_o, 0);
      check_stream(from, 4, "irq");
      chk("irq_after_frame", irq_o, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
